// File: rtl/nf10_input_arbiter_wrr.sv
// nf10_input_arbiter_wrr
// Packet-granularity input arbiter. It merges C_NUM_PORTS AXI4-Stream slave ports into one
// master stream. Scheduling is weighted round-robin (arb_mode = 0) or strict priority with
// port 0 highest (arb_mode = 1). A port keeps its grant for a whole packet. The arbiter also
// keeps a completed-packet counter for each port.
//
// Ports (per-port buses are flattened, port i at slice [i*W +: W]):
//   axi_aclk, axi_reset           clock and synchronous active-high reset
//   s_axis_*                      slave streams (tdata/tstrb/tuser/tvalid/tready/tlast)
//   m_axis_*                      merged master stream
//   arb_mode                      0 = weighted round-robin, 1 = strict priority
//   port_weight                   packets per grant for each port (0 is treated as 1)
//   stat_clear                    synchronous clear of all packet counters
//   stat_pkt_count                per-port completed-packet counters
//   cur_port                      currently or last granted port
module nf10_input_arbiter_wrr #(
    parameter int unsigned C_NUM_PORTS        = 5,
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_WEIGHT_WIDTH     = 4,
    parameter int unsigned C_STAT_WIDTH       = 32,
    localparam int unsigned StrbW = C_AXIS_DATA_WIDTH / 8,
    localparam int unsigned PortW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1
) (
    input  logic                                       axi_aclk,
    input  logic                                       axi_reset,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_NUM_PORTS*StrbW-1:0]               s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                     s_axis_tvalid,
    output logic [C_NUM_PORTS-1:0]                     s_axis_tready,
    input  logic [C_NUM_PORTS-1:0]                     s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [StrbW-1:0]                           m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]              m_axis_tuser,
    output logic                                       m_axis_tlast,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    input  logic                                       arb_mode,
    input  logic [C_NUM_PORTS*C_WEIGHT_WIDTH-1:0]      port_weight,
    input  logic                                       stat_clear,
    output logic [C_NUM_PORTS*C_STAT_WIDTH-1:0]        stat_pkt_count,
    output logic [PortW-1:0]                           cur_port
);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e                    state_q, state_d;
    logic [PortW-1:0]          cur_port_q, cur_port_d;
    logic [C_WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic [C_STAT_WIDTH-1:0]   stat_q [C_NUM_PORTS];
    logic [C_STAT_WIDTH-1:0]   stat_d [C_NUM_PORTS];

    logic                      xfer;
    logic                      last_hs;
    logic [PortW-1:0]          rr_winner;
    logic [PortW-1:0]          sp_winner;
    logic [PortW-1:0]          winner;
    logic                      rr_found;
    logic [C_WEIGHT_WIDTH-1:0] win_weight;

    assign xfer     = (state_q == StXfer);
    assign last_hs  = xfer && s_axis_tvalid[cur_port_q] && m_axis_tready
                      && s_axis_tlast[cur_port_q];
    assign cur_port = cur_port_q;

    // Round-robin search starts one past the last grant and wraps from N-1 to 0.
    always_comb begin
        rr_winner = cur_port_q;
        rr_found  = 1'b0;
        for (int unsigned i = 1; i <= C_NUM_PORTS; i++) begin
            if (!rr_found && s_axis_tvalid[(32'(cur_port_q) + i) % C_NUM_PORTS]) begin
                rr_winner = PortW'((32'(cur_port_q) + i) % C_NUM_PORTS);
                rr_found  = 1'b1;
            end
        end
    end

    // Descending scan so the lowest valid index is the last one written.
    always_comb begin
        sp_winner = '0;
        for (int i = C_NUM_PORTS - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                sp_winner = PortW'(i);
            end
        end
    end

    assign winner     = arb_mode ? sp_winner : rr_winner;
    assign win_weight = port_weight[winner*C_WEIGHT_WIDTH +: C_WEIGHT_WIDTH];

    // Next-state: grant decision in idle, packet completion in transfer.
    always_comb begin
        state_d    = state_q;
        cur_port_d = cur_port_q;
        credit_d   = credit_q;
        case (state_q)
            StIdle: begin
                if (|s_axis_tvalid) begin
                    state_d = StXfer;
                    // Remaining credit lets the current port keep going without a reload.
                    if (!(!arb_mode && (credit_q != '0) && s_axis_tvalid[cur_port_q])) begin
                        cur_port_d = winner;
                        credit_d   = (win_weight == '0) ? C_WEIGHT_WIDTH'(1) : win_weight;
                    end
                end
            end
            StXfer: begin
                if (last_hs) begin
                    state_d = StIdle;
                    if (credit_q != '0) begin
                        credit_d = credit_q - C_WEIGHT_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath mux: combinational from the slave inputs and the registered grant.
    always_comb begin
        m_axis_tdata  = s_axis_tdata[cur_port_q*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        m_axis_tstrb  = s_axis_tstrb[cur_port_q*StrbW +: StrbW];
        m_axis_tuser  = s_axis_tuser[cur_port_q*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        m_axis_tlast  = s_axis_tlast[cur_port_q];
        m_axis_tvalid = xfer && s_axis_tvalid[cur_port_q];
        s_axis_tready = '0;
        if (xfer) begin
            s_axis_tready[cur_port_q] = m_axis_tready;
        end
    end

    // Packet counters; clear takes precedence over a coincident increment.
    always_comb begin
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            stat_d[i] = stat_q[i];
            if (stat_clear) begin
                stat_d[i] = '0;
            end else if (last_hs && (cur_port_q == PortW'(i))) begin
                stat_d[i] = stat_q[i] + C_STAT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        stat_pkt_count = '0;
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            stat_pkt_count[i*C_STAT_WIDTH +: C_STAT_WIDTH] = stat_q[i];
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q    <= StIdle;
            cur_port_q <= PortW'(C_NUM_PORTS - 1);
            credit_q   <= '0;
            for (int i = 0; i < C_NUM_PORTS; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_port_q <= cur_port_d;
            credit_q   <= credit_d;
            for (int i = 0; i < C_NUM_PORTS; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

endmodule

// File: tb/tb_nf10_input_arbiter_wrr.sv
// Directed testbench for nf10_input_arbiter_wrr (5 ports, narrow data for readability).
module tb_nf10_input_arbiter_wrr;

    localparam int unsigned N  = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned UW = 8;
    localparam int unsigned WW = 4;
    localparam int unsigned CW = 32;

    logic              axi_aclk = 1'b0;
    logic              axi_reset;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N*SW-1:0]   s_axis_tstrb;
    logic [N*UW-1:0]   s_axis_tuser;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tready;
    logic [N-1:0]      s_axis_tlast;
    logic [DW-1:0]     m_axis_tdata;
    logic [SW-1:0]     m_axis_tstrb;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              arb_mode;
    logic [N*WW-1:0]   port_weight;
    logic              stat_clear;
    logic [N*CW-1:0]   stat_pkt_count;
    logic [2:0]        cur_port;

    int passes = 0;
    int total  = 0;

    nf10_input_arbiter_wrr #(
        .C_NUM_PORTS       (N),
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_WEIGHT_WIDTH    (WW),
        .C_STAT_WIDTH      (CW)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_reset     (axi_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .arb_mode      (arb_mode),
        .port_weight   (port_weight),
        .stat_clear    (stat_clear),
        .stat_pkt_count(stat_pkt_count),
        .cur_port      (cur_port)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic l, input logic [DW-1:0] d);
        s_axis_tvalid[p]          = v;
        s_axis_tlast[p]           = l;
        s_axis_tdata[p*DW +: DW]  = d;
        s_axis_tstrb[p*SW +: SW]  = 4'hF;
        s_axis_tuser[p*UW +: UW]  = 8'h50 + 8'(p);
    endtask

    function automatic logic [CW-1:0] cnt(input int p);
        return stat_pkt_count[p*CW +: CW];
    endfunction

    task automatic do_reset();
        axi_reset = 1'b1;
        tick();
        tick();
        axi_reset = 1'b0;
    endtask

    // One single-beat packet from an idle start: bubble cycle, then the transfer cycle.
    task automatic one_pkt(input int p);
        #1;
        chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("idle_tready", 64'(s_axis_tready), 64'd0);
        tick();
        chk("grant", 64'(cur_port), 64'(p));
        chk("mdata", 64'(m_axis_tdata), 64'(32'hA000_0000 + p));
        chk("muser", 64'(m_axis_tuser), 64'(8'h50 + p));
        chk("mvalid", 64'(m_axis_tvalid), 64'd1);
        chk("sready", 64'(s_axis_tready), 64'(5'd1 << p));
        tick();
    endtask

    initial begin
        int wrr_order [10] = '{0, 0, 0, 1, 2, 3, 4, 0, 0, 0};
        int b;
        axi_reset     = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        arb_mode      = 1'b0;
        port_weight   = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        stat_clear    = 1'b0;
        tick();
        tick();

        // Reset state.
        chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_sready", 64'(s_axis_tready), 64'd0);
        chk("rst_cur", 64'(cur_port), 64'd4);
        chk("rst_cnt0", 64'(cnt(0)), 64'd0);

        // Round-robin, weights 1: order 0,1,2,3,4,0.
        axi_reset = 1'b0;
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b1, 32'hA000_0000 + p);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin
                for (int p = 0; p < N; p++) chk("rr_cnt", 64'(cnt(p)), 64'd1);
            end
            one_pkt(k % N);
        end
        chk("rr_cnt0_wrap", 64'(cnt(0)), 64'd2);

        // Weighted round-robin {3,1,1,1,1}.
        port_weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd3};
        do_reset();
        for (int k = 0; k < 10; k++) one_pkt(wrr_order[k]);
        chk("wrr_cnt0", 64'(cnt(0)), 64'd6);

        // Strict priority: ports 2 and 4 valid, port 2 always wins.
        do_reset();
        s_axis_tvalid = '0;
        arb_mode = 1'b1;
        set_port(2, 1'b1, 1'b1, 32'hA000_0002);
        set_port(4, 1'b1, 1'b1, 32'hA000_0004);
        for (int k = 0; k < 3; k++) one_pkt(2);
        s_axis_tvalid[2] = 1'b0;
        one_pkt(4);
        s_axis_tvalid = '0;
        chk("sp_cnt4", 64'(cnt(4)), 64'd1);

        // Port 1 four-beat packet with toggling backpressure; port 3 arrives mid-packet.
        arb_mode = 1'b0;
        set_port(1, 1'b1, 1'b0, 32'hB000_0000);
        #1;
        chk("bp_idle", 64'(m_axis_tvalid), 64'd0);
        tick();
        chk("bp_grant", 64'(cur_port), 64'd1);
        b = 0;
        for (int c = 0; c < 20 && b < 4; c++) begin
            m_axis_tready = (c % 2 == 0);
            set_port(1, 1'b1, (b == 3), 32'hB000_0000 + b);
            if (c == 1) set_port(3, 1'b1, 1'b1, 32'hA000_0003);
            #1;
            chk("bp_data", 64'(m_axis_tdata), 64'(32'hB000_0000 + b));
            chk("bp_last", 64'(m_axis_tlast), 64'(b == 3));
            chk("bp_valid", 64'(m_axis_tvalid), 64'd1);
            chk("bp_ready", 64'(s_axis_tready), m_axis_tready ? 64'h2 : 64'h0);
            chk("bp_cnt1", 64'(cnt(1)), 64'd0);
            if (m_axis_tready) b++;
            tick();
        end
        chk("bp_beats", 64'(b), 64'd4);
        chk("bp_cnt1_done", 64'(cnt(1)), 64'd1);
        m_axis_tready = 1'b1;
        s_axis_tvalid[1] = 1'b0;
        one_pkt(3);
        s_axis_tvalid = '0;

        // Clear wins over a coincident tlast increment on port 0.
        set_port(0, 1'b1, 1'b1, 32'hA000_0000);
        one_pkt(0);
        chk("clr_pre", 64'(cnt(0)), 64'd1);
        #1;
        chk("clr_idle", 64'(m_axis_tvalid), 64'd0);
        tick();
        chk("clr_grant", 64'(cur_port), 64'd0);
        stat_clear = 1'b1;
        #1;
        chk("clr_hs", 64'(m_axis_tvalid && m_axis_tlast), 64'd1);
        tick();
        stat_clear = 1'b0;
        chk("clr_cnt0", 64'(cnt(0)), 64'd0);
        chk("clr_cnt1", 64'(cnt(1)), 64'd0);
        s_axis_tvalid = '0;

        // Reset at beat 2 of a four-beat packet on port 2.
        set_port(2, 1'b1, 1'b0, 32'hC000_0000);
        tick();
        chk("mid_grant", 64'(cur_port), 64'd2);
        tick();
        tick();
        axi_reset = 1'b1;
        #1;
        chk("mid_valid_pre", 64'(m_axis_tvalid), 64'd1);
        tick();
        chk("mid_mvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_sready", 64'(s_axis_tready), 64'd0);
        chk("mid_cur", 64'(cur_port), 64'd4);
        axi_reset = 1'b0;
        s_axis_tvalid = '0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
